pipe_rca: RTL and testbench

- Parametrised, pipelined ripple-carry adder: next generation of the team's 4-bit RCA.
- Splits a WIDTH-bit carry chain into STAGES registered segments, so wide adds close timing at high clock rates.
- Adds a valid/ready stream handshake with backpressure, plus signed-overflow reporting.
- Sits between operand producers and result consumers in datapath pipelines.

---
 rtl/rca_seg.sv | 29 ++
 rtl/pipe_rca.sv | 126 ++++++++++++
 tb/tb_pipe_rca.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rca_seg.sv
// Combinational SEG-bit ripple-carry adder segment.
// Also exposes the carry into its top bit so the caller can detect signed overflow.
module rca_seg #(
    parameter int SEG = 4
) (
    input  logic [SEG-1:0] a,
    input  logic [SEG-1:0] b,
    input  logic           c_in,
    output logic [SEG-1:0] s,
    output logic           c_out,
    output logic           c_msb_in
);

    logic [SEG:0] c;

    always_comb begin
        c    = '0;
        s    = '0;
        c[0] = c_in;
        for (int i = 0; i < SEG; i++) begin
            s[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
    end

    assign c_out    = c[SEG];
    assign c_msb_in = c[SEG-1];

endmodule

// File: rtl/pipe_rca.sv
// Pipelined ripple-carry adder: the WIDTH-bit carry chain is cut into STAGES
// registered segments, with a valid/ready handshake and signed-overflow flag.
module pipe_rca #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             c_out,
    output logic             ovf
);

    localparam int SEG = WIDTH / STAGES;

    if ((STAGES < 1) || (STAGES > WIDTH) || (WIDTH % STAGES != 0)) begin : g_param_chk
        $error("pipe_rca: WIDTH must be a multiple of STAGES and 1 <= STAGES <= WIDTH");
    end

    function automatic logic signed_ovf(input logic c_msb_in, input logic c_msb_out);
        return c_msb_in ^ c_msb_out;
    endfunction

    logic             adv;
    logic             ovf_p;

    // Per-stage registers: valid, completed low sum slices, chain carry, and
    // the operand skew copies still needed by the stages further down.
    logic             vld_p   [STAGES];
    logic [WIDTH-1:0] sum_p   [STAGES];
    logic             carry_p [STAGES];
    logic [WIDTH-1:0] a_p     [STAGES];
    logic [WIDTH-1:0] b_p     [STAGES];

    logic             nxt_vld [STAGES];
    logic [WIDTH-1:0] nxt_sum [STAGES];
    logic [WIDTH-1:0] nxt_a   [STAGES];
    logic [WIDTH-1:0] nxt_b   [STAGES];
    logic             co_w    [STAGES];
    logic             cm_w    [STAGES];

    // A single global enable: the whole pipe moves or the whole pipe holds.
    assign adv      = !(vld_p[STAGES-1] && !out_ready);
    assign in_ready = rst_n && adv;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [SEG-1:0]   seg_a;
        logic [SEG-1:0]   seg_b;
        logic [SEG-1:0]   seg_s;
        logic             seg_ci;
        logic [WIDTH-1:0] prev_sum;
        logic [WIDTH-1:0] sum_w;

        if (k == 0) begin : g_head
            assign seg_a      = a[SEG-1:0];
            assign seg_b      = b[SEG-1:0];
            assign seg_ci     = c_in;
            assign prev_sum   = '0;
            assign nxt_vld[k] = in_valid;
            assign nxt_a[k]   = a;
            assign nxt_b[k]   = b;
        end else begin : g_body
            assign seg_a      = a_p[k-1][k*SEG +: SEG];
            assign seg_b      = b_p[k-1][k*SEG +: SEG];
            assign seg_ci     = carry_p[k-1];
            assign prev_sum   = sum_p[k-1];
            assign nxt_vld[k] = vld_p[k-1];
            assign nxt_a[k]   = a_p[k-1];
            assign nxt_b[k]   = b_p[k-1];
        end

        rca_seg #(
            .SEG (SEG)
        ) u_seg (
            .a        (seg_a),
            .b        (seg_b),
            .c_in     (seg_ci),
            .s        (seg_s),
            .c_out    (co_w[k]),
            .c_msb_in (cm_w[k])
        );

        always_comb begin
            sum_w                = prev_sum;
            sum_w[k*SEG +: SEG] = seg_s;
        end

        assign nxt_sum[k] = sum_w;
    end

    // Stage register boundary
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < STAGES; i++) begin
                vld_p[i]   <= 1'b0;
                sum_p[i]   <= '0;
                carry_p[i] <= 1'b0;
                a_p[i]     <= '0;
                b_p[i]     <= '0;
            end
            ovf_p <= 1'b0;
        end else if (adv) begin
            for (int i = 0; i < STAGES; i++) begin
                vld_p[i]   <= nxt_vld[i];
                sum_p[i]   <= nxt_sum[i];
                carry_p[i] <= co_w[i];
                a_p[i]     <= nxt_a[i];
                b_p[i]     <= nxt_b[i];
            end
            ovf_p <= signed_ovf(cm_w[STAGES-1], co_w[STAGES-1]);
        end
    end

    assign out_valid = vld_p[STAGES-1];
    assign s         = sum_p[STAGES-1];
    assign c_out     = carry_p[STAGES-1];
    assign ovf       = ovf_p;

endmodule

// File: tb/tb_pipe_rca.sv
// Bench for pipe_rca: directed vectors, backpressure/reset sequences, and a
// randomized stream checked against a plain-arithmetic reference model.
module tb_pipe_rca;

    localparam int W = 16;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] es;
        logic         ec;
        logic         eovf;
        string        name;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst_n, in_valid, out_ready, c_in, iv_aux, or_aux;
    logic [W-1:0] a, b;
    logic         in_ready, out_valid, c_out, ovf;
    logic [W-1:0] s;
    logic         ir1, ov1, co1, of1;
    logic [W-1:0] s1;
    logic         ir16, ov16, co16, of16;
    logic [W-1:0] s16;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipe_rca #(.WIDTH(W), .STAGES(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .c_in(c_in), .out_valid(out_valid), .out_ready(out_ready),
        .s(s), .c_out(c_out), .ovf(ovf)
    );

    pipe_rca #(.WIDTH(W), .STAGES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv_aux), .in_ready(ir1),
        .a(a), .b(b), .c_in(c_in), .out_valid(ov1), .out_ready(or_aux),
        .s(s1), .c_out(co1), .ovf(of1)
    );

    pipe_rca #(.WIDTH(W), .STAGES(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv_aux), .in_ready(ir16),
        .a(a), .b(b), .c_in(c_in), .out_valid(ov16), .out_ready(or_aux),
        .s(s16), .c_out(co16), .ovf(of16)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference: {ovf, carry, sum} from the arithmetic definition of the add.
    function automatic logic [17:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y,
                                            input logic ci);
        logic [W:0] full;
        logic       v;
        full = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
        v    = (x[W-1] == y[W-1]) && (full[W-1] != x[W-1]);
        return {v, full[W], full[W-1:0]};
    endfunction

    task automatic wait_valid(input string nm);
        int n;
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_arrive"}, {31'd0, out_valid}, 32'd1);
    endtask

    task automatic single(input vec_t v);
        int edges;
        a = v.a; b = v.b; c_in = v.cin; in_valid = 1'b1;
        @(negedge clk);
        chk({v.name, "_ready"}, {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        edges = 1;
        @(negedge clk);
        while (!out_valid && edges < 20) begin
            @(posedge clk); #1;
            edges++;
            @(negedge clk);
        end
        chk({v.name, "_lat"}, edges, 32'd4);
        chk(v.name, {13'd0, out_valid, ovf, c_out, s}, {13'd0, 1'b1, v.eovf, v.ec, v.es});
        @(posedge clk); #1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t         tbl [8];
        vec_t         strm [3];
        vec_t         bp [4];
        logic [31:0]  held;
        logic [17:0]  r;
        logic [17:0]  r1, r16;
        logic [17:0]  q [$];
        logic         prev_hold;
        int           lat1, lat16, stale, n;

        tbl[0] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, "ripple"};
        tbl[1] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, "ovf_pos"};
        tbl[2] = '{16'h000B, 16'h000C, 1'b1, 16'h0018, 1'b0, 1'b0, "small_cin"};
        tbl[3] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0, "all_ones"};
        tbl[4] = '{16'h8000, 16'hFFFF, 1'b0, 16'h7FFF, 1'b1, 1'b1, "ovf_neg"};
        tbl[5] = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0, "cin_only"};
        tbl[6] = '{16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0, "seg_cross"};
        tbl[7] = '{16'h0FFF, 16'h0FFF, 1'b1, 16'h1FFF, 1'b0, 1'b0, "multi_seg"};

        strm[0] = '{16'h0001, 16'h0002, 1'b0, 16'h0003, 1'b0, 1'b0, "stream0"};
        strm[1] = '{16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0, "stream1"};
        strm[2] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, "stream2"};

        bp[0] = '{16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0, "bp0"};
        bp[1] = '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0, "bp1"};
        bp[2] = '{16'h4000, 16'h4000, 1'b0, 16'h8000, 1'b0, 1'b1, "bp2"};
        bp[3] = '{16'h1111, 16'h2222, 1'b1, 16'h3334, 1'b0, 1'b0, "bp3"};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; iv_aux = 1'b0; or_aux = 1'b1;
        a = '0; b = '0; c_in = 1'b0;

        // Reset with inputs toggling
        for (int i = 0; i < 3; i++) begin
            a = W'($urandom); b = W'($urandom); c_in = 1'($urandom); in_valid = 1'($urandom);
            @(negedge clk);
            chk("reset_outs", {12'd0, out_valid, in_ready, c_out, ovf, s}, 32'd0);
            chk("reset_aux", {28'd0, ov1, ir1, ov16, ir16}, 32'd0);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        rst_n    = 1'b1;
        @(negedge clk);
        chk("ready_after_reset", {31'd0, in_ready}, 32'd1);
        chk("valid_after_reset", {31'd0, out_valid}, 32'd0);
        @(posedge clk); #1;

        // Directed single beats with latency
        for (int i = 0; i < 8; i++) single(tbl[i]);

        // Back-to-back streaming
        for (int j = 0; j < 3; j++) begin
            a = strm[j].a; b = strm[j].b; c_in = strm[j].cin; in_valid = 1'b1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        wait_valid("stream");
        for (int j = 0; j < 3; j++) begin
            if (j > 0) begin
                @(posedge clk); #1;
                @(negedge clk);
            end
            chk(strm[j].name, {13'd0, out_valid, ovf, c_out, s},
                {13'd0, 1'b1, strm[j].eovf, strm[j].ec, strm[j].es});
        end
        @(posedge clk); #1;
        @(negedge clk);
        chk("stream_empty", {31'd0, out_valid}, 32'd0);
        @(posedge clk); #1;

        // Backpressure: fill, stall with junk offered, then drain
        for (int j = 0; j < 4; j++) begin
            a = bp[j].a; b = bp[j].b; c_in = bp[j].cin; in_valid = 1'b1;
            @(posedge clk); #1;
        end
        a = 16'hDEAD; b = 16'hBEEF; c_in = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        held = {13'd0, out_valid, ovf, c_out, s};
        chk("bp_first", held, {13'd0, 1'b1, bp[0].eovf, bp[0].ec, bp[0].es});
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk("bp_ready", {31'd0, in_ready}, 32'd0);
            chk("bp_hold", {13'd0, out_valid, ovf, c_out, s}, held);
        end
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b1;
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            chk(bp[j].name, {13'd0, out_valid, ovf, c_out, s},
                {13'd0, 1'b1, bp[j].eovf, bp[j].ec, bp[j].es});
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("bp_empty", {31'd0, out_valid}, 32'd0);
        @(posedge clk); #1;

        // Reset mid-operation with three beats in flight
        for (int j = 0; j < 3; j++) begin
            a = W'(j + 7); b = W'(j + 1); c_in = 1'b0; in_valid = 1'b1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("mid_prefill", {31'd0, out_valid}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_async", {12'd0, out_valid, in_ready, c_out, ovf, s}, 32'd0);
        @(posedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
        stale = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (out_valid) stale++;
            @(posedge clk); #1;
        end
        chk("mid_no_stale", stale, 32'd0);
        single('{16'h0005, 16'h0005, 1'b0, 16'h000A, 1'b0, 1'b0, "mid_fresh"});

        // Ripple case on the STAGES=1 and STAGES=16 instances
        a = 16'hFFFF; b = 16'h0001; c_in = 1'b0; iv_aux = 1'b1;
        @(negedge clk);
        chk("aux_ready", {30'd0, ir1, ir16}, 32'd3);
        @(posedge clk); #1;
        iv_aux = 1'b0;
        lat1 = 0; lat16 = 0; r1 = '0; r16 = '0;
        for (int e = 1; e <= 20; e++) begin
            @(negedge clk);
            if (ov1 && lat1 == 0) begin lat1 = e; r1 = {of1, co1, s1}; end
            if (ov16 && lat16 == 0) begin lat16 = e; r16 = {of16, co16, s16}; end
            @(posedge clk); #1;
        end
        chk("s1_lat", lat1, 32'd1);
        chk("s1_ripple", {14'd0, r1}, 32'h0001_0000);
        chk("s16_lat", lat16, 32'd16);
        chk("s16_ripple", {14'd0, r16}, 32'h0001_0000);

        // Randomized stream against the reference model
        prev_hold = 1'b0;
        held      = '0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            a = W'($urandom); b = W'($urandom); c_in = 1'($urandom);
            @(negedge clk);
            if (prev_hold) chk("rnd_hold", {13'd0, out_valid, ovf, c_out, s}, held);
            if (out_valid && !out_ready) chk("rnd_stall_ready", {31'd0, in_ready}, 32'd0);
            if (out_valid && out_ready) begin
                chk("rnd_expected_item", {31'd0, q.size() > 0}, 32'd1);
                if (q.size() > 0) begin
                    r = q.pop_front();
                    chk("rnd_data", {14'd0, ovf, c_out, s}, {14'd0, r});
                end
            end
            if (in_valid && in_ready) q.push_back(ref_add(a, b, c_in));
            prev_hold = out_valid && !out_ready;
            held      = {13'd0, out_valid, ovf, c_out, s};
            @(posedge clk); #1;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        n = 0;
        while (q.size() > 0 && n < 40) begin
            @(negedge clk);
            if (out_valid) begin
                r = q.pop_front();
                chk("rnd_drain", {14'd0, ovf, c_out, s}, {14'd0, r});
            end
            @(posedge clk); #1;
            n++;
        end
        chk("rnd_all_out", q.size(), 32'd0);
        @(negedge clk);
        chk("rnd_final_idle", {31'd0, out_valid}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
